u_rec_gen: RTL and testbench

U_REC_GEN -- requirements
Module: u_rec_gen

---
 rtl/u_rec_gen_if.sv | 13 +
 rtl/u_rec_gen.sv | 111 +++++++++++
 tb/tb_u_rec_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/u_rec_gen_if.sv
// u_rec_gen_if: receive handshake bundle of u_rec_gen.
//   master (receiver side): rx_ackH in; rx_dataH, rx_validH, frame_errH, parity_errH, overrunH out.
//   slave  (consumer side): the same signals with opposite directions.
interface u_rec_gen_if #(parameter int DATA_BITS = 8);
  logic                 rx_ackH;
  logic [DATA_BITS-1:0] rx_dataH;
  logic                 rx_validH;
  logic                 frame_errH;
  logic                 parity_errH;
  logic                 overrunH;
  modport master (input rx_ackH, output rx_dataH, rx_validH, frame_errH, parity_errH, overrunH);
  modport slave (output rx_ackH, input rx_dataH, rx_validH, frame_errH, parity_errH, overrunH);
endinterface

// File: rtl/u_rec_gen.sv
// u_rec_gen: oversampling UART receiver with a one-word holding register and ack handshake.
//   Params: DATA_BITS 5..8, OVS sys_clk cycles per bit (even, 4..64), STOP_BITS 1..2, PARITY_ODD 0/1.
//   Ports : sys_clk, sys_rst_l (async, active low), uart_dataH (serial line, idle high, LSB first),
//           rx (u_rec_gen_if.master): rx_ackH in; rx_dataH, rx_validH, frame_errH, parity_errH, overrunH out.
//   Build : define UART_RX_PARITY_EN to add the parity bit and its check; otherwise parity_errH stays 0.
module u_rec_gen #(
  parameter int DATA_BITS  = 8,
  parameter int OVS        = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst_l,
  input  logic        uart_dataH,
  u_rec_gen_if.master rx
);
  localparam int CW = $clog2(OVS);
  if (DATA_BITS < 5 || DATA_BITS > 8 || OVS < 4 || OVS > 64 || OVS % 2 != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("u_rec_gen: parameter out of range");
  end
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif
  state_t               state_q;
  logic                 sync1_q, sync2_q;
  logic [CW-1:0]        cnt_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic                 fr_bad_q, par_bad_q, commit_q;
  logic                 valid_q, ferr_q, perr_q, ovr_q;
  logic                 smp, ack;
  // Start bit and first stop bit are taken half a cell in; the stop bit is checked early so the
  // receiver is back in IDLE well before the next start edge.
  assign smp = cnt_q == ((state_q == START || (state_q == STOP && bit_q == 4'd0)) ? CW'(OVS/2-1) : CW'(OVS-1));
  assign ack = rx.rx_ackH & valid_q;
  always_ff @(posedge sys_clk or negedge sys_rst_l)
    if (!sys_rst_l) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      fr_bad_q  <= 1'b0;
      par_bad_q <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      sync1_q  <= uart_dataH;
      sync2_q  <= sync1_q;
      commit_q <= 1'b0;
      cnt_q    <= (state_q == IDLE || state_q == BREAK || smp) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: if (!sync2_q) state_q <= START;
        START: if (smp) begin
          state_q   <= sync2_q ? IDLE : DATA;
          fr_bad_q  <= 1'b0;
          par_bad_q <= 1'b0;
        end
        DATA: if (smp) begin
          shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
          bit_q   <= (bit_q == 4'(DATA_BITS-1)) ? 4'd0 : bit_q + 4'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 4'(DATA_BITS-1)) state_q <= PARITY;
`else
          if (bit_q == 4'(DATA_BITS-1)) state_q <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (smp) begin
          par_bad_q <= (^{shift_q, sync2_q}) ^ (PARITY_ODD != 0);
          state_q   <= STOP;
        end
`endif
        STOP: if (smp) begin
          fr_bad_q <= fr_bad_q | !sync2_q;
          bit_q    <= (bit_q == 4'(STOP_BITS-1)) ? 4'd0 : bit_q + 4'd1;
          if (bit_q == 4'(STOP_BITS-1)) begin
            commit_q <= 1'b1;
            state_q  <= sync2_q ? IDLE : BREAK;
          end
        end
        BREAK: if (sync2_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  // A commit onto an unacknowledged word is dropped and flagged; an ack in the same cycle frees the slot.
  always_ff @(posedge sys_clk or negedge sys_rst_l)
    if (!sys_rst_l) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (commit_q && (!valid_q || ack)) begin
        data_q <= shift_q;
        ferr_q <= fr_bad_q;
        perr_q <= par_bad_q;
      end
      valid_q <= commit_q | (valid_q & !ack);
      ovr_q   <= !ack & (ovr_q | (commit_q & valid_q));
    end
  assign rx.rx_dataH    = data_q;
  assign rx.rx_validH   = valid_q;
  assign rx.frame_errH  = ferr_q;
  assign rx.parity_errH = perr_q;
  assign rx.overrunH    = ovr_q;
endmodule

// File: tb/tb_u_rec_gen.sv
// tb_u_rec_gen: randomized self-checking bench for u_rec_gen against a frame-level reference model.
module tb_u_rec_gen;
  localparam int OVS0 = 16;
  localparam int OVS1 = 8;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0_n, rst1_n, line0, line1;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int failures = 0;
  int fall_c = 0;
  int lat0 = 148;
  u_rec_gen_if #(.DATA_BITS(8)) if0 ();
  u_rec_gen_if #(.DATA_BITS(5)) if1 ();
  u_rec_gen #(.DATA_BITS(8), .OVS(OVS0), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .sys_clk(clk), .sys_rst_l(rst0_n), .uart_dataH(line0), .rx(if0));
  u_rec_gen #(.DATA_BITS(5), .OVS(OVS1), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .sys_clk(clk), .sys_rst_l(rst1_n), .uart_dataH(line1), .rx(if1));
  int rises0 = 0, rise_cyc0 = 0, rises1 = 0;
  logic pv0 = 1'b0, pv1 = 1'b0;
  always @(negedge clk) begin
    if (if0.rx_validH && !pv0) begin rises0++; rise_cyc0 = cyc; end
    if (if1.rx_validH && !pv1) rises1++;
    pv0 = if0.rx_validH;
    pv1 = if1.rx_validH;
  end
  logic       m_valid, m_ovr, m_ferr, m_perr;
  logic [7:0] m_data;
  function automatic void m_frame(input logic [7:0] d, input bit fe, input bit pe);
    if (m_valid) m_ovr = 1'b1;
    else begin m_data = d; m_ferr = fe; m_perr = pe; m_valid = 1'b1; end
  endfunction
  function automatic void m_ack();
    if (m_valid) begin m_valid = 1'b0; m_ovr = 1'b0; end
  endfunction
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) line1 = v; else line0 = v;
    idle(n);
  endtask
  task automatic send(input bit sel, input logic [7:0] d, input bit stop_ok, input bit par_bad);
    int nb, ns, ovs;
    nb = sel ? 5 : 8;
    ns = sel ? 2 : 1;
    ovs = sel ? OVS1 : OVS0;
    fall_c = cyc;
    drive(sel, 1'b0, ovs);
    for (int i = 0; i < nb; i++) drive(sel, d[i], ovs);
    if (P == 1) drive(sel, (^d) ^ par_bad, ovs);
    for (int i = 0; i < ns; i++) drive(sel, stop_ok, ovs);
  endtask
  task automatic ack0();
    if0.rx_ackH = 1'b1;
    idle(1);
    if0.rx_ackH = 1'b0;
    m_ack();
  endtask
  task automatic test_reset();
    idle(3);
    checks++; if (if0.rx_validH !== 1'b0) begin failures++; $display("FAIL reset_valid0 got=%0b exp=0", if0.rx_validH); end
    checks++; if (if0.rx_dataH !== 8'h00) begin failures++; $display("FAIL reset_data0 got=%0h exp=0", if0.rx_dataH); end
    checks++; if (if0.frame_errH !== 1'b0) begin failures++; $display("FAIL reset_ferr0 got=%0b exp=0", if0.frame_errH); end
    checks++; if (if0.parity_errH !== 1'b0) begin failures++; $display("FAIL reset_perr0 got=%0b exp=0", if0.parity_errH); end
    checks++; if (if0.overrunH !== 1'b0) begin failures++; $display("FAIL reset_ovr0 got=%0b exp=0", if0.overrunH); end
    checks++; if (if1.rx_validH !== 1'b0) begin failures++; $display("FAIL reset_valid1 got=%0b exp=0", if1.rx_validH); end
    checks++; if (if1.rx_dataH !== 5'h00) begin failures++; $display("FAIL reset_data1 got=%0h exp=0", if1.rx_dataH); end
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    idle(4);
  endtask
  task automatic test_basic();
    int r, lat, exp_lat;
    r = rises0;
    send(0, 8'hA5, 1'b1, 1'b0);
    m_frame(8'hA5, 1'b0, 1'b0);
    idle(2);
    lat = rise_cyc0 - fall_c;
    lat0 = lat;
    exp_lat = 3 + OVS0 * (8 + P + 1);
    checks++; if (rises0 - r !== 1) begin failures++; $display("FAIL basic_commits got=%0d exp=1", rises0 - r); end
    checks++; if (lat < exp_lat - 1 || lat > exp_lat + 1) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d+/-1", lat, exp_lat); end
    checks++; if (if0.rx_validH !== m_valid) begin failures++; $display("FAIL basic_valid got=%0b exp=%0b", if0.rx_validH, m_valid); end
    checks++; if (if0.rx_dataH !== m_data) begin failures++; $display("FAIL basic_data got=%0h exp=%0h", if0.rx_dataH, m_data); end
    checks++; if (if0.frame_errH !== 1'b0) begin failures++; $display("FAIL basic_ferr got=%0b exp=0", if0.frame_errH); end
    ack0();
    checks++; if (if0.rx_validH !== 1'b0) begin failures++; $display("FAIL basic_ack_clear got=%0b exp=0", if0.rx_validH); end
    checks++; if (if0.rx_dataH !== 8'hA5) begin failures++; $display("FAIL basic_data_hold got=%0h exp=a5", if0.rx_dataH); end
  endtask
  task automatic test_glitch();
    int r;
    r = rises0;
    drive(0, 1'b0, 5);
    drive(0, 1'b1, 3 * OVS0);
    checks++; if (rises0 !== r || if0.rx_validH !== 1'b0) begin failures++; $display("FAIL glitch_no_commit got=%0d,%0b exp=%0d,0", rises0, if0.rx_validH, r); end
    send(0, 8'h3C, 1'b1, 1'b0);
    m_frame(8'h3C, 1'b0, 1'b0);
    idle(4);
    checks++; if (if0.rx_validH !== 1'b1) begin failures++; $display("FAIL glitch_valid got=%0b exp=1", if0.rx_validH); end
    checks++; if (if0.rx_dataH !== 8'h3C) begin failures++; $display("FAIL glitch_data got=%0h exp=3c", if0.rx_dataH); end
    ack0();
  endtask
  task automatic test_break();
    int r;
    r = rises0;
    send(0, 8'h11, 1'b0, 1'b0);
    m_frame(8'h11, 1'b1, 1'b0);
    drive(0, 1'b0, 39 * OVS0);
    drive(0, 1'b1, 2 * OVS0);
    checks++; if (rises0 - r !== 1) begin failures++; $display("FAIL break_commits got=%0d exp=1", rises0 - r); end
    checks++; if (if0.overrunH !== 1'b0) begin failures++; $display("FAIL break_ovr got=%0b exp=0", if0.overrunH); end
    checks++; if (if0.frame_errH !== 1'b1) begin failures++; $display("FAIL break_ferr got=%0b exp=1", if0.frame_errH); end
    checks++; if (if0.rx_dataH !== 8'h11) begin failures++; $display("FAIL break_data got=%0h exp=11", if0.rx_dataH); end
    ack0();
    send(0, 8'h22, 1'b1, 1'b0);
    m_frame(8'h22, 1'b0, 1'b0);
    idle(4);
    checks++; if (if0.rx_dataH !== 8'h22 || if0.frame_errH !== 1'b0) begin failures++; $display("FAIL break_recover got=%0h,%0b exp=22,0", if0.rx_dataH, if0.frame_errH); end
    ack0();
  endtask
  task automatic test_overrun();
    send(0, 8'h55, 1'b1, 1'b0);
    m_frame(8'h55, 1'b0, 1'b0);
    send(0, 8'h66, 1'b1, 1'b0);
    m_frame(8'h66, 1'b0, 1'b0);
    idle(OVS0);
    checks++; if (if0.rx_dataH !== m_data) begin failures++; $display("FAIL ovr_data got=%0h exp=%0h", if0.rx_dataH, m_data); end
    checks++; if (if0.overrunH !== m_ovr) begin failures++; $display("FAIL ovr_flag got=%0b exp=%0b", if0.overrunH, m_ovr); end
    checks++; if (if0.rx_validH !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%0b exp=1", if0.rx_validH); end
    ack0();
    checks++; if (if0.overrunH !== 1'b0 || if0.rx_validH !== 1'b0) begin failures++; $display("FAIL ovr_ack_clear got=%0b,%0b exp=0,0", if0.overrunH, if0.rx_validH); end
    send(0, 8'h55, 1'b1, 1'b0);
    idle(OVS0);
    fork
      send(0, 8'h66, 1'b1, 1'b0);
      begin
        repeat (lat0 - 1) @(posedge clk);
        #1 if0.rx_ackH = 1'b1;
        idle(1);
        if0.rx_ackH = 1'b0;
      end
    join
    idle(4);
    checks++; if (if0.rx_dataH !== 8'h66) begin failures++; $display("FAIL ack_commit_data got=%0h exp=66", if0.rx_dataH); end
    checks++; if (if0.overrunH !== 1'b0 || if0.rx_validH !== 1'b1) begin failures++; $display("FAIL ack_commit_flags got=%0b,%0b exp=0,1", if0.overrunH, if0.rx_validH); end
    m_data = 8'h66; m_valid = 1'b1; m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    ack0();
  endtask
  task automatic test_parity();
    send(0, 8'h07, 1'b1, 1'b0);
    idle(4);
    checks++; if (if0.parity_errH !== 1'b0) begin failures++; $display("FAIL parity_good got=%0b exp=0", if0.parity_errH); end
    ack0();
`ifdef UART_RX_PARITY_EN
    send(0, 8'h07, 1'b1, 1'b1);
    idle(4);
    checks++; if (if0.parity_errH !== 1'b1) begin failures++; $display("FAIL parity_bad got=%0b exp=1", if0.parity_errH); end
    ack0();
`endif
  endtask
  task automatic test_random();
    logic [7:0] d;
    bit stop_ok, pb;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      stop_ok = $urandom_range(0, 3) != 0;
      pb = (P == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(0, d, stop_ok, pb);
      m_frame(d, !stop_ok, pb);
      if (!stop_ok) drive(0, 1'b1, OVS0);
      idle(OVS0);
      checks++; if (if0.rx_validH !== m_valid) begin failures++; $display("FAIL rnd%0d_valid got=%0b exp=%0b", i, if0.rx_validH, m_valid); end
      checks++; if (if0.rx_dataH !== m_data) begin failures++; $display("FAIL rnd%0d_data got=%0h exp=%0h", i, if0.rx_dataH, m_data); end
      checks++; if (if0.frame_errH !== m_ferr) begin failures++; $display("FAIL rnd%0d_ferr got=%0b exp=%0b", i, if0.frame_errH, m_ferr); end
      checks++; if (if0.parity_errH !== m_perr) begin failures++; $display("FAIL rnd%0d_perr got=%0b exp=%0b", i, if0.parity_errH, m_perr); end
      checks++; if (if0.overrunH !== m_ovr) begin failures++; $display("FAIL rnd%0d_ovr got=%0b exp=%0b", i, if0.overrunH, m_ovr); end
      if ($urandom_range(0, 1) == 1) ack0();
    end
    ack0();
  endtask
  task automatic test_cfg5();
    int r;
    send(1, 8'h1F, 1'b1, 1'b0);
    idle(4);
    checks++; if (if1.rx_validH !== 1'b1) begin failures++; $display("FAIL cfg5_valid got=%0b exp=1", if1.rx_validH); end
    checks++; if (if1.rx_dataH !== 5'h1F) begin failures++; $display("FAIL cfg5_data got=%0h exp=1f", if1.rx_dataH); end
    checks++; if (if1.frame_errH !== 1'b0) begin failures++; $display("FAIL cfg5_ferr got=%0b exp=0", if1.frame_errH); end
    if1.rx_ackH = 1'b1;
    idle(1);
    if1.rx_ackH = 1'b0;
    r = rises1;
    fork
      send(1, 8'h19, 1'b1, 1'b0);
      begin
        repeat (4 * OVS1 + OVS1 / 2) @(posedge clk);
        #1 rst1_n = 1'b0;
        idle(2);
        rst1_n = 1'b1;
      end
    join
    idle(2 * OVS1);
    checks++; if (rises1 !== r || if1.rx_validH !== 1'b0) begin failures++; $display("FAIL cfg5_abort_commit got=%0d,%0b exp=%0d,0", rises1, if1.rx_validH, r); end
    checks++; if (if1.rx_dataH !== 5'h00) begin failures++; $display("FAIL cfg5_abort_data got=%0h exp=0", if1.rx_dataH); end
    checks++; if ({if1.frame_errH, if1.parity_errH, if1.overrunH} !== 3'b000) begin failures++; $display("FAIL cfg5_abort_flags got=%0b exp=000", {if1.frame_errH, if1.parity_errH, if1.overrunH}); end
    send(1, 8'h0A, 1'b1, 1'b0);
    idle(4);
    checks++; if (if1.rx_validH !== 1'b1 || if1.rx_dataH !== 5'h0A) begin failures++; $display("FAIL cfg5_resume got=%0b,%0h exp=1,0a", if1.rx_validH, if1.rx_dataH); end
  endtask
  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    line0 = 1'b1;
    line1 = 1'b1;
    if0.rx_ackH = 1'b0;
    if1.rx_ackH = 1'b0;
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_data = 8'h00;
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
    test_parity();
    test_random();
    test_cfg5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
